risc_mem_arbiter: RTL and testbench

//  Shares the single byte-wide memory (mem[0..0xFFF], little-endian words) between

---
 rtl/risc_mem_pkg.sv | 16 +
 rtl/risc_mem_beat_seq.sv | 84 ++++++++
 rtl/risc_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_risc_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_mem_pkg.sv
// Shared types and constants for the RISC memory arbiter (state encoding, owner IDs, beat count).
package risc_mem_pkg;
  localparam int BEATS      = 4;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;
endpackage

// File: rtl/risc_mem_beat_seq.sv
// Byte-beat sequencer: walks four consecutive byte addresses (wrapping), drives the
// byte write strobe per enable and assembles read bytes into a little-endian word.
module risc_mem_beat_seq
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [31:0]       i_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_last,
  output logic [31:0]       o_word,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata
);
  logic              r_active;
  logic [1:0]        r_beat;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;
  logic [1:0]        w_beat_nxt;
  logic [31:0]       w_word;

  assign w_beat_nxt = r_beat + 2'd1;

  // The word including the byte being read this beat, so the final lane is usable on the last edge.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    assign w_word[8*gi +: 8] = (r_active && !r_we && (r_beat == 2'(gi))) ?
                               i_mem_rdata : r_word[8*gi +: 8];
  end

  assign o_last      = r_active && (r_beat == 2'(BEATS - 1));
  assign o_word      = w_word;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_we    = r_mem_we;
  assign o_mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active    <= 1'b0;
      r_beat      <= 2'd0;
      r_we        <= 1'b0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_word      <= 32'd0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
    end else if (i_start) begin
      r_active    <= 1'b1;
      r_beat      <= 2'd0;
      r_we        <= i_we;
      r_be        <= i_be;
      r_wdata     <= i_we ? i_wdata : 32'd0;
      r_word      <= 32'd0;
      r_mem_addr  <= i_addr;
      r_mem_we    <= i_we & i_be[0];
      r_mem_wdata <= i_we ? i_wdata[7:0] : 8'd0;
    end else if (r_active) begin
      r_word <= w_word;
      if (o_last) begin
        r_active    <= 1'b0;
        r_mem_addr  <= '0;
        r_mem_we    <= 1'b0;
        r_mem_wdata <= 8'd0;
      end else begin
        r_beat      <= w_beat_nxt;
        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
        r_mem_we    <= r_we & r_be[w_beat_nxt];
        r_mem_wdata <= r_wdata[8*w_beat_nxt +: 8];
      end
    end
  end
endmodule

// File: rtl/risc_mem_arbiter.sv
// IF/DM arbiter for the shared byte memory: DM priority with IF anti-starvation.
// Optional RISC_MEM_ALIGN_CHECK_EN rejects misaligned words with err instead of sequencing them.
module risc_mem_arbiter
  import risc_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [3:0]        dm_be,
  input  logic [31:0]       dm_wdata,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t            r_state;
  owner_t            r_owner;
  logic              r_we;
  logic              r_err_pend;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_if_done;
  logic              r_dm_done;
  logic              r_err;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_dm_rdata;

  logic              w_grant;
  logic              w_grant_dm;
  logic              w_grant_if;
  logic [ADDR_W-1:0] w_addr;
  logic              w_misalign;
  logic              w_start;
  logic              w_last;
  logic [31:0]       w_word;

  assign w_grant    = (r_state == ST_IDLE) && (if_req || dm_req);
  assign w_grant_dm = dm_req && (!if_req || (r_starve_cnt != CNT_W'(STARVE_MAX)));
  assign w_grant_if = if_req && !w_grant_dm;
  assign w_addr     = w_grant_dm ? dm_addr : if_addr;
`ifdef RISC_MEM_ALIGN_CHECK_EN
  assign w_misalign = (w_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_start    = w_grant && !w_misalign;

  risc_mem_beat_seq #(.ADDR_W(ADDR_W)) u_beat_seq (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_start),
    .i_addr      (w_addr),
    .i_we        (w_grant_dm & dm_we),
    .i_be        (dm_be),
    .i_wdata     (dm_wdata),
    .i_mem_rdata (mem_rdata),
    .o_last      (w_last),
    .o_word      (w_word),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata)
  );

  assign if_done  = r_if_done;
  assign dm_done  = r_dm_done;
  assign err      = r_err;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_we         <= 1'b0;
      r_err_pend   <= 1'b0;
      r_starve_cnt <= '0;
      r_if_done    <= 1'b0;
      r_dm_done    <= 1'b0;
      r_err        <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_dm_rdata   <= 32'd0;
    end else begin
      r_if_done <= 1'b0;
      r_dm_done <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Starvation only accumulates while IF is actually waiting.
          if (!if_req || w_grant_if)
            r_starve_cnt <= '0;
          else if (w_grant_dm && (r_starve_cnt != CNT_W'(STARVE_MAX)))
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
          if (w_grant) begin
            r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
            r_we    <= w_grant_dm & dm_we;
            if (w_misalign) begin
              r_state    <= ST_DONE;
              r_err_pend <= 1'b1;
            end else begin
              r_state <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (w_last) begin
            r_state <= ST_DONE;
            if (r_owner == OWN_IF) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_word;
            end else begin
              r_dm_done <= 1'b1;
              if (!r_we)
                r_dm_rdata <= w_word;
            end
          end
        end
        ST_DONE: begin
          // A rejected access spends one DONE cycle arming the error response, then pulses it.
          if (r_err_pend) begin
            r_err_pend <= 1'b0;
            r_err      <= 1'b1;
            if (r_owner == OWN_IF) begin
              r_if_done  <= 1'b1;
              r_if_rdata <= 32'd0;
            end else begin
              r_dm_done  <= 1'b1;
              r_dm_rdata <= 32'd0;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Scoreboard bench for risc_mem_arbiter with a byte-memory model; RISC_MEM_ALIGN_CHECK_EN selects the misalign scenario.
module tb_risc_mem_arbiter;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [3:0]        dm_be;
  logic [31:0]       dm_wdata;
  logic              dm_done;
  logic [31:0]       dm_rdata;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  risc_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory model with a backdoor write port for preloading
  logic [7:0]        mem [0:4095];
  logic              bk_we;
  logic [ADDR_W-1:0] bk_addr;
  logic [7:0]        bk_data;
  int                we_count = 0;
  int                done_count = 0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (bk_we)  mem[bk_addr]  <= bk_data;
  end

  always @(posedge clk) begin
    if (mem_we) we_count <= we_count + 1;
    if (if_done || dm_done) done_count <= done_count + 1;
  end

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_dm_rdata;

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  task automatic push_exp(input logic is_dm, input logic [31:0] data, input logic e_err, input int lat);
    exp_t e;
    e.is_dm = is_dm; e.data = data; e.err = e_err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Waits for one done pulse, pops the scoreboard and compares; returns with the DUT in its done cycle.
  task automatic wait_and_check(input string name);
    exp_t        e;
    int          n;
    logic        got;
    logic [1:0]  exp_dn;
    logic [31:0] obs;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = if_done || dm_done;
    end
    e = sb.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s timeout: no done within 20 cycles", name);
      return;
    end
    exp_dn = e.is_dm ? 2'b01 : 2'b10;
    obs = e.is_dm ? dm_rdata : if_rdata;
    checks++;
    if ({if_done, dm_done} !== exp_dn) begin
      failures++; $display("FAIL %s owner: {if_done,dm_done}=%b expected %b", name, {if_done, dm_done}, exp_dn);
    end
    checks++;
    if (n !== e.lat) begin
      failures++; $display("FAIL %s latency: got %0d expected %0d", name, n, e.lat);
    end
    checks++;
    if (obs !== e.data) begin
      failures++; $display("FAIL %s rdata: got %h expected %h", name, obs, e.data);
    end
    checks++;
    if (err !== e.err) begin
      failures++; $display("FAIL %s err: got %b expected %b", name, err, e.err);
    end
    $display("txn %s: owner=%s lat=%0d rdata=%h err=%b", name, e.is_dm ? "DM" : "IF", n, obs, err);
  endtask

  task automatic dm_access(input string name, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] exp_data, input logic e_err, input int lat);
    @(negedge clk);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_be = be; dm_wdata = wd;
    push_exp(1'b1, exp_data, e_err, lat);
    wait_and_check(name);
    dm_req = 1'b0; dm_we = 1'b0;
    model_dm_rdata = exp_data;
  endtask

  task automatic check_mem(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
    checks++;
    if (mem[a] !== exp) begin
      failures++; $display("FAIL %s mem[%h]: got %h expected %h", name, a, mem[a], exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({if_done, dm_done, err, mem_we} !== 4'b0000) begin
      failures++; $display("FAIL %s strobes: if_done/dm_done/err/mem_we=%b expected 0000", name, {if_done, dm_done, err, mem_we});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== 8'd0) begin
      failures++; $display("FAIL %s mem bus: addr=%h wdata=%h expected 0", name, mem_addr, mem_wdata);
    end
    checks++;
    if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin
      failures++; $display("FAIL %s rdata: if=%h dm=%h expected 0", name, if_rdata, dm_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    model_dm_rdata = 32'd0;
    $display("txn reset: outputs checked");
  endtask

  task automatic test_fetch();
    poke(12'h010, 8'h78); poke(12'h011, 8'h56); poke(12'h012, 8'h34); poke(12'h013, 8'h12);
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'h010;
    push_exp(1'b0, 32'h12345678, 1'b0, 5);
    wait_and_check("fetch");
    if_req = 1'b0;
  endtask

  task automatic test_store_be();
    poke(12'h020, 8'h00); poke(12'h021, 8'h11); poke(12'h022, 8'h22); poke(12'h023, 8'h33);
    dm_access("load_pre", 1'b0, 12'h010, 4'b0000, 32'd0, 32'h12345678, 1'b0, 5);
    dm_access("store_be", 1'b1, 12'h020, 4'b0101, 32'hAABBCCDD, model_dm_rdata, 1'b0, 5);
    @(negedge clk);
    check_mem("store_be", 12'h020, 8'hDD);
    check_mem("store_be", 12'h021, 8'h11);
    check_mem("store_be", 12'h022, 8'hBB);
    check_mem("store_be", 12'h023, 8'h33);
    dm_access("load_back", 1'b0, 12'h020, 4'b0000, 32'd0, 32'h33BB11DD, 1'b0, 5);
  endtask

  task automatic test_contention();
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'h020;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h010;
    for (int k = 0; k < 6; k++)
      push_exp((k != 4), (k != 4) ? 32'h12345678 : 32'h33BB11DD, 1'b0, (k == 0) ? 5 : 6);
    for (int k = 0; k < 6; k++)
      wait_and_check($sformatf("contend%0d", k));
    if_req = 1'b0; dm_req = 1'b0;
    model_dm_rdata = 32'h12345678;
  endtask

`ifndef RISC_MEM_ALIGN_CHECK_EN
  task automatic test_wrap();
    poke(12'hFFE, 8'h01); poke(12'hFFF, 8'h02); poke(12'h000, 8'h03); poke(12'h001, 8'h04);
    dm_access("wrap", 1'b0, 12'hFFE, 4'b0000, 32'd0, 32'h04030201, 1'b0, 5);
  endtask
`else
  task automatic test_misalign();
    int we_before;
    we_before = we_count;
    dm_access("misalign", 1'b1, 12'h003, 4'b1111, 32'hCAFEF00D, 32'd0, 1'b1, 2);
    @(negedge clk);
    checks++;
    if (we_count !== we_before) begin
      failures++; $display("FAIL misalign mem_we: %0d write strobes expected 0", we_count - we_before);
    end
  endtask
`endif

  task automatic test_reset_mid_store();
    int done_before;
    poke(12'h040, 8'hEE); poke(12'h041, 8'hEE); poke(12'h042, 8'hEE); poke(12'h043, 8'hEE);
    done_before = done_count;
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h040; dm_be = 4'b1111; dm_wdata = 32'h44332211;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dm_req = 1'b0; dm_we = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++; $display("FAIL reset_mid mem_we: got %b expected 0", mem_we);
    end
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_mid");
    check_mem("reset_mid", 12'h040, 8'h11);
    check_mem("reset_mid", 12'h041, 8'h22);
    check_mem("reset_mid", 12'h042, 8'hEE);
    check_mem("reset_mid", 12'h043, 8'hEE);
    checks++;
    if (done_count !== done_before) begin
      failures++; $display("FAIL reset_mid done: %0d done pulses expected 0", done_count - done_before);
    end
    reset = 1'b0;
    $display("txn reset_mid: store aborted");
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_be = 4'd0; dm_wdata = 32'd0;
    bk_we = 1'b0; bk_addr = '0; bk_data = 8'd0;
    model_dm_rdata = 32'd0;
    test_reset();
    test_fetch();
    test_store_be();
    test_contention();
`ifndef RISC_MEM_ALIGN_CHECK_EN
    test_wrap();
`else
    test_misalign();
`endif
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
